// File: rtl/alu_stage_seq_if.sv
// Request/result bundle between the multicycle control FSM and the registered execute-stage ALU.
interface alu_stage_seq_if #(
  parameter int WIDTH = 32
);
  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] RF_A;
  logic [WIDTH-1:0] RF_B;
  logic [WIDTH-1:0] Immed;
  logic             ALU_Bin_sel;
  logic [WIDTH-1:0] lui_out;
  logic             lui;
  logic [3:0]       ALU_func;
  logic [WIDTH-1:0] ALU_out;
  logic             Zero;
  logic             Ovf;
  logic             Out_valid;
  logic             Busy;

  modport master (
    output In_valid, RF_A, RF_B, Immed, ALU_Bin_sel, lui_out, lui, ALU_func,
    input  In_ready, ALU_out, Zero, Ovf, Out_valid, Busy
  );

  modport slave (
    input  In_valid, RF_A, RF_B, Immed, ALU_Bin_sel, lui_out, lui, ALU_func,
    output In_ready, ALU_out, Zero, Ovf, Out_valid, Busy
  );
endinterface

// File: rtl/alu_stage_seq.sv
// Registered execute-stage ALU: single-op latency 1, MULU latency WIDTH (shift-add, one bit per clock).
// In_ready drops while a multiply runs; requests seen while busy are dropped, not queued.
module alu_stage_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          Clk,
  input  logic          Reset,
  alu_stage_seq_if.slave bus
);
  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0001;
  localparam logic [3:0] F_AND  = 4'b0010;
  localparam logic [3:0] F_OR   = 4'b0011;
  localparam logic [3:0] F_NOT  = 4'b0100;
  localparam logic [3:0] F_NAND = 4'b0101;
  localparam logic [3:0] F_NOR  = 4'b0110;
  localparam logic [3:0] F_MULU = 4'b0111;
  localparam logic [3:0] F_SRA  = 4'b1000;
  localparam logic [3:0] F_SLL  = 4'b1001;
  localparam logic [3:0] F_SRL  = 4'b1010;
  localparam logic [3:0] F_ROL  = 4'b1100;
  localparam logic [3:0] F_ROR  = 4'b1101;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mplr_q, acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept, is_mulu, mul_last;
  logic [WIDTH-1:0] a, opb, sum, diff, res, acc_add;
  logic             res_ovf;

  assign a        = bus.RF_A;
  assign opb      = bus.lui ? bus.lui_out : (bus.ALU_Bin_sel ? bus.Immed : bus.RF_B);
  assign sum      = a + opb;
  assign diff     = a - opb;
  assign is_mulu  = (bus.ALU_func == F_MULU);
  assign accept   = bus.In_valid && (state_q == IDLE);
  assign mul_last = (state_q == MUL) && (cnt_q == CNT_W'(WIDTH - 1));
  assign acc_add  = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (bus.ALU_func)
      F_ADD: begin
        res     = sum;
        res_ovf = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      F_SUB: begin
        res     = diff;
        res_ovf = (a[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      F_AND:  res = a & opb;
      F_OR:   res = a | opb;
      F_NOT:  res = ~a;
      F_NAND: res = ~(a & opb);
      F_NOR:  res = ~(a | opb);
      F_SRA:  res = {a[WIDTH-1], a[WIDTH-1:1]};
      F_SLL:  res = {a[WIDTH-2:0], 1'b0};
      F_SRL:  res = {1'b0, a[WIDTH-1:1]};
      F_ROL:  res = {a[WIDTH-2:0], a[WIDTH-1]};
      F_ROR:  res = {a[0], a[WIDTH-1:1]};
      default: begin
        res     = '0;
        res_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mulu) state_d = MUL;
      MUL:     if (mul_last)          state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy     = (state_q == MUL);
    bus.In_ready = (state_q == IDLE);
  end

  // The final iteration's sum is written straight to ALU_out so completion lands on edge N+WIDTH.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.ALU_out   <= '0;
      bus.Zero      <= 1'b1;
      bus.Ovf       <= 1'b0;
      bus.Out_valid <= 1'b0;
      mcand_q       <= '0;
      mplr_q        <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
    end else begin
      bus.Out_valid <= 1'b0;
      if (accept) begin
        if (is_mulu) begin
          mcand_q <= a;
          mplr_q  <= opb;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          bus.ALU_out   <= res;
          bus.Zero      <= (res == '0);
          bus.Ovf       <= res_ovf;
          bus.Out_valid <= 1'b1;
        end
      end else if (state_q == MUL) begin
        acc_q   <= acc_add;
        mcand_q <= {mcand_q[WIDTH-2:0], 1'b0};
        mplr_q  <= {1'b0, mplr_q[WIDTH-1:1]};
        cnt_q   <= cnt_q + CNT_W'(1);
        if (mul_last) begin
          bus.ALU_out   <= acc_add;
          bus.Zero      <= (acc_add == '0);
          bus.Ovf       <= 1'b0;
          bus.Out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_stage_seq.sv
// Directed bench for alu_stage_seq: hand-computed vectors for every op, MULU timing, reset abort, back-to-back.
module tb_alu_stage_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  alu_stage_seq_if #(.WIDTH(32)) bus ();

  alu_stage_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic sel, input logic luiv, input logic [31:0] luio,
                        input logic [3:0] f);
    bus.RF_A        = a;
    bus.RF_B        = b;
    bus.Immed       = imm;
    bus.ALU_Bin_sel = sel;
    bus.lui         = luiv;
    bus.lui_out     = luio;
    bus.ALU_func    = f;
  endtask

  // Presents the op for exactly one rising edge (the acceptance edge), returns #1 after it.
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic sel, input logic luiv, input logic [31:0] luio,
                           input logic [3:0] f);
    set_op(a, b, imm, sel, luiv, luio, f);
    bus.In_valid = 1'b1;
    @(posedge clk); #1;
    bus.In_valid = 1'b0;
  endtask

  task automatic test_reset();
    set_op(32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
    bus.In_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    bus.In_valid = 1'b0;
    vec_cnt++; if (bus.ALU_out !== 32'd0) begin err_cnt++; $display("FAIL reset_alu_out got %h want 0", bus.ALU_out); end
    vec_cnt++; if (bus.Zero !== 1'b1) begin err_cnt++; $display("FAIL reset_zero got %b want 1", bus.Zero); end
    vec_cnt++; if (bus.Ovf !== 1'b0) begin err_cnt++; $display("FAIL reset_ovf got %b want 0", bus.Ovf); end
    vec_cnt++; if (bus.Out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", bus.Out_valid); end
    vec_cnt++; if (bus.Busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    vec_cnt++; if (bus.In_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", bus.In_ready); end
  endtask

  task automatic test_add();
    accept_op(32'd15, 32'd1, 32'd99, 1'b0, 1'b0, 32'd0, 4'b0000);
    vec_cnt++; if (bus.Out_valid !== 1'b1) begin err_cnt++; $display("FAIL add_out_valid got %b want 1", bus.Out_valid); end
    vec_cnt++; if (bus.ALU_out !== 32'd16) begin err_cnt++; $display("FAIL add_result got %h want 10", bus.ALU_out); end
    vec_cnt++; if (bus.Zero !== 1'b0 || bus.Ovf !== 1'b0) begin err_cnt++; $display("FAIL add_flags got z=%b o=%b want 0 0", bus.Zero, bus.Ovf); end
    @(posedge clk); #1;
    vec_cnt++; if (bus.Out_valid !== 1'b0) begin err_cnt++; $display("FAIL add_pulse_width got %b want 0", bus.Out_valid); end
    vec_cnt++; if (bus.ALU_out !== 32'd16) begin err_cnt++; $display("FAIL add_hold got %h want 10", bus.ALU_out); end
  endtask

  task automatic test_sub_lui();
    accept_op(32'd5, 32'd77, 32'd5, 1'b1, 1'b0, 32'd0, 4'b0001);
    vec_cnt++; if (bus.ALU_out !== 32'd0 || bus.Zero !== 1'b1) begin err_cnt++; $display("FAIL sub_imm got %h z=%b want 0 z=1", bus.ALU_out, bus.Zero); end
    accept_op(32'd0, 32'd77, 32'h0000_1234, 1'b1, 1'b1, 32'h0005_0000, 4'b0000);
    vec_cnt++; if (bus.ALU_out !== 32'h0005_0000 || bus.Zero !== 1'b0) begin err_cnt++; $display("FAIL lui_override got %h z=%b want 00050000 z=0", bus.ALU_out, bus.Zero); end
  endtask

  task automatic test_ovf_shift();
    accept_op(32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
    vec_cnt++; if (bus.ALU_out !== 32'h8000_0000 || bus.Ovf !== 1'b1) begin err_cnt++; $display("FAIL add_ovf got %h o=%b want 80000000 o=1", bus.ALU_out, bus.Ovf); end
    accept_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0001);
    vec_cnt++; if (bus.ALU_out !== 32'h7FFF_FFFF || bus.Ovf !== 1'b1) begin err_cnt++; $display("FAIL sub_ovf got %h o=%b want 7fffffff o=1", bus.ALU_out, bus.Ovf); end
    accept_op(32'h8000_0001, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'b1101);
    vec_cnt++; if (bus.ALU_out !== 32'hC000_0000 || bus.Ovf !== 1'b0) begin err_cnt++; $display("FAIL ror got %h o=%b want c0000000 o=0", bus.ALU_out, bus.Ovf); end
    accept_op(32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'b1000);
    vec_cnt++; if (bus.ALU_out !== 32'hC000_0000) begin err_cnt++; $display("FAIL sra got %h want c0000000", bus.ALU_out); end
  endtask

  task automatic test_logic_table();
    logic [3:0]  fn  [11];
    logic [31:0] va  [11];
    logic [31:0] vb  [11];
    logic [31:0] exp [11];
    logic        eo  [11];
    fn[0]  = 4'b0010; va[0]  = 32'hF0F0_00FF; vb[0]  = 32'h0FF0_0F0F; exp[0]  = 32'h00F0_000F; eo[0]  = 1'b0;
    fn[1]  = 4'b0011; va[1]  = 32'hF0F0_00FF; vb[1]  = 32'h0FF0_0F0F; exp[1]  = 32'hFFF0_0FFF; eo[1]  = 1'b0;
    fn[2]  = 4'b0100; va[2]  = 32'hF0F0_00FF; vb[2]  = 32'h0FF0_0F0F; exp[2]  = 32'h0F0F_FF00; eo[2]  = 1'b0;
    fn[3]  = 4'b0101; va[3]  = 32'hF0F0_00FF; vb[3]  = 32'h0FF0_0F0F; exp[3]  = 32'hFF0F_FFF0; eo[3]  = 1'b0;
    fn[4]  = 4'b0110; va[4]  = 32'hF0F0_00FF; vb[4]  = 32'h0FF0_0F0F; exp[4]  = 32'h000F_F000; eo[4]  = 1'b0;
    fn[5]  = 4'b1001; va[5]  = 32'hF0F0_00FF; vb[5]  = 32'h0;         exp[5]  = 32'hE1E0_01FE; eo[5]  = 1'b0;
    fn[6]  = 4'b1010; va[6]  = 32'hF0F0_00FF; vb[6]  = 32'h0;         exp[6]  = 32'h7878_007F; eo[6]  = 1'b0;
    fn[7]  = 4'b1100; va[7]  = 32'hF0F0_00FF; vb[7]  = 32'h0;         exp[7]  = 32'hE1E0_01FF; eo[7]  = 1'b0;
    fn[8]  = 4'b0000; va[8]  = 32'hFFFF_FFFF; vb[8]  = 32'd1;         exp[8]  = 32'h0;         eo[8]  = 1'b0;
    fn[9]  = 4'b0001; va[9]  = 32'd3;         vb[9]  = 32'd5;         exp[9]  = 32'hFFFF_FFFE; eo[9]  = 1'b0;
    fn[10] = 4'b1011; va[10] = 32'h1234_5678; vb[10] = 32'h1;         exp[10] = 32'h0;         eo[10] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      accept_op(va[i], vb[i], 32'd0, 1'b0, 1'b0, 32'd0, fn[i]);
      vec_cnt++;
      if (bus.Out_valid !== 1'b1 || bus.ALU_out !== exp[i] || bus.Ovf !== eo[i] || bus.Zero !== (exp[i] == 32'd0)) begin
        err_cnt++;
        $display("FAIL logic_op[%0d] f=%b got v=%b %h z=%b o=%b want v=1 %h o=%b", i, fn[i], bus.Out_valid, bus.ALU_out, bus.Zero, bus.Ovf, exp[i], eo[i]);
      end
    end
  endtask

  task automatic test_mulu();
    int bad;
    int lat;
    accept_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0111);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (bus.Busy !== 1'b1 || bus.In_ready !== 1'b0 || bus.Out_valid !== 1'b0) bad++;
      if (i == 4) begin
        set_op(32'd100, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
        bus.In_valid = 1'b1;
      end else begin
        bus.In_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    vec_cnt++; if (bad !== 0) begin err_cnt++; $display("FAIL mulu_busy_window got %0d bad cycles want 0", bad); end
    vec_cnt++; if (bus.Out_valid !== 1'b1 || bus.ALU_out !== 32'd42) begin err_cnt++; $display("FAIL mulu_7x6 got v=%b %h want v=1 2a", bus.Out_valid, bus.ALU_out); end
    vec_cnt++; if (bus.Busy !== 1'b0 || bus.In_ready !== 1'b1 || bus.Zero !== 1'b0 || bus.Ovf !== 1'b0) begin err_cnt++; $display("FAIL mulu_done_flags got b=%b r=%b z=%b o=%b want 0 1 0 0", bus.Busy, bus.In_ready, bus.Zero, bus.Ovf); end
    @(posedge clk); #1;
    vec_cnt++; if (bus.Out_valid !== 1'b0 || bus.ALU_out !== 32'd42) begin err_cnt++; $display("FAIL mulu_pulse got v=%b %h want v=0 2a", bus.Out_valid, bus.ALU_out); end
    accept_op(32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0111);
    lat = 0;
    while (bus.Out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    vec_cnt++; if (lat !== 32) begin err_cnt++; $display("FAIL mulu_latency got %0d want 32", lat); end
    vec_cnt++; if (bus.ALU_out !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL mulu_wrap got %h want fffffffe", bus.ALU_out); end
  endtask

  task automatic test_reset_mid_mul();
    int pulses;
    accept_op(32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0111);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vec_cnt++; if (bus.Busy !== 1'b0 || bus.In_ready !== 1'b1) begin err_cnt++; $display("FAIL abort_ctrl got b=%b r=%b want 0 1", bus.Busy, bus.In_ready); end
    vec_cnt++; if (bus.ALU_out !== 32'd0 || bus.Zero !== 1'b1 || bus.Out_valid !== 1'b0) begin err_cnt++; $display("FAIL abort_out got %h z=%b v=%b want 0 1 0", bus.ALU_out, bus.Zero, bus.Out_valid); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.Out_valid === 1'b1) pulses++;
    end
    vec_cnt++; if (pulses !== 0) begin err_cnt++; $display("FAIL abort_no_valid got %0d pulses want 0", pulses); end
    accept_op(32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
    vec_cnt++; if (bus.Out_valid !== 1'b1 || bus.ALU_out !== 32'd5) begin err_cnt++; $display("FAIL abort_then_add got v=%b %h want v=1 5", bus.Out_valid, bus.ALU_out); end
  endtask

  task automatic test_back_to_back();
    accept_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0111);
    repeat (31) @(posedge clk);
    #1;
    set_op(32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
    bus.In_valid = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (bus.Out_valid !== 1'b1 || bus.ALU_out !== 32'd42) begin err_cnt++; $display("FAIL b2b_first got v=%b %h want v=1 2a", bus.Out_valid, bus.ALU_out); end
    @(posedge clk); #1;
    bus.In_valid = 1'b0;
    vec_cnt++; if (bus.Out_valid !== 1'b1 || bus.ALU_out !== 32'd5) begin err_cnt++; $display("FAIL b2b_second got v=%b %h want v=1 5", bus.Out_valid, bus.ALU_out); end
    @(posedge clk); #1;
    vec_cnt++; if (bus.Out_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_end got v=%b want 0", bus.Out_valid); end
    accept_op(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0, 4'b1111);
    vec_cnt++; if (bus.ALU_out !== 32'd0 || bus.Zero !== 1'b1 || bus.Ovf !== 1'b0) begin err_cnt++; $display("FAIL unused_code got %h z=%b o=%b want 0 1 0", bus.ALU_out, bus.Zero, bus.Ovf); end
  endtask

  initial begin
    bus.In_valid = 1'b0;
    set_op(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 4'b0000);
    test_reset();
    test_add();
    test_sub_lui();
    test_ovf_shift();
    test_logic_table();
    test_mulu();
    test_reset_mid_mul();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vec_cnt);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_stage_seq.md
Name: alu_stage_seq

Overview:
- Parametrised, registered successor to the execute-stage ALU of the MIPS datapath.
- Selects operand B from RF_B, Immed or lui_out and executes the same function set as the current ALU.
- Adds a registered result with a valid/ready handshake, a signed-overflow flag, and a multi-cycle unsigned multiply (shift-add, one bit per clock).
- Sits between register-file read and the memory/writeback stage; the multicycle control FSM sequences it using In_ready/Out_valid.

Parameters:
- WIDTH, 32, datapath width in bits (must be ≥ 4).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- In_valid  in  1  operation request; accepted on a rising edge when In_valid && In_ready.
- In_ready  out  1  high when the block can accept an operation (= ~Busy).
- RF_A  in  WIDTH  operand A.
- RF_B  in  WIDTH  register operand B.
- Immed  in  WIDTH  immediate operand B.
- ALU_Bin_sel  in  1  0 selects RF_B, 1 selects Immed.
- lui_out  in  WIDTH  LUI-shifted immediate.
- lui  in  1  1 forces operand B = lui_out (overrides ALU_Bin_sel).
- ALU_func  in  4  operation code.
- ALU_out  out  WIDTH  registered result.
- Zero  out  1  registered; 1 when the captured result == 0.
- Ovf  out  1  registered signed overflow (ADD/SUB only, 0 otherwise).
- Out_valid  out  1  one-cycle pulse: ALU_out/Zero/Ovf updated this cycle.
- Busy  out  1  multiply in progress.

Behaviour:
- Operand B = lui ? lui_out : (ALU_Bin_sel ? Immed : RF_B). It is sampled only at acceptance; later input changes do not affect an in-flight operation.
- ALU_func codes:
  - 0000 ADD A+B.
  - 0001 SUB A−B.
  - 0010 AND.
  - 0011 OR.
  - 0100 NOT A.
  - 0101 NAND.
  - 0110 NOR.
  - 0111 MULU: low WIDTH bits of the unsigned A×B, multi-cycle.
  - 1000 SRA A by 1.
  - 1001 SLL A by 1.
  - 1010 SRL A by 1.
  - 1100 ROL A by 1.
  - 1101 ROR A by 1.
  - Any other code: result 0, Ovf 0, Zero 1.
- All arithmetic is modulo 2^WIDTH.
- Ovf:
  - ADD: sign(A)==sign(B) && sign(sum)!=sign(A).
  - SUB: sign(A)!=sign(B) && sign(diff)!=sign(A).
- FSM states: IDLE, MUL.
- IDLE, non-MULU op accepted at edge N:
  - ALU_out/Zero/Ovf are loaded at edge N.
  - Out_valid is high for the cycle following edge N (latency 1). The FSM stays in IDLE.
- IDLE, MULU op accepted at edge N:
  - Latch multiplicand = A, multiplier = B, accumulator = 0, counter = 0.
  - Busy=1 and In_ready=0 from edge N.
  - Go to MUL.
- MUL: each edge adds the multiplicand to the accumulator if multiplier LSB = 1, then shifts the multiplicand left 1 and the multiplier right 1, and increments the counter.
- MUL completion, at the edge where the counter reaches WIDTH (edge N+WIDTH):
  - Load ALU_out = accumulator, Zero = (accumulator == 0), Ovf = 0.
  - Out_valid pulses for one cycle; Busy drops at the same edge; return to IDLE.
  - In_ready is high in the cycle following completion, so back-to-back accepts are allowed.
- In_valid while Busy is ignored: no queueing and no effect on the in-flight operation.
- ALU_out/Zero/Ovf hold their last values between results. Out_valid is never high for two consecutive cycles from a single operation.
- Reset (synchronous, takes priority over everything including mid-multiply):
  - ALU_out=0, Zero=1, Ovf=0, Out_valid=0, Busy=0, In_ready=1.
  - State = IDLE, counter = 0; any in-flight multiply is discarded with no Out_valid.
  - In_valid on the reset edge is not accepted.

Test Plan:
1. WIDTH=32. A=15, RF_B=1, Bin_sel=0, lui=0, func=0000, In_valid for 1 cycle -> next cycle ALU_out=16, Zero=0, Ovf=0, Out_valid=1 for exactly 1 cycle.
2. A=5, Immed=5, Bin_sel=1, func=0001 -> ALU_out=0, Zero=1. Then lui=1, lui_out=0x00050000, A=0, Bin_sel=1, func=0000 -> ALU_out=0x00050000 (lui overrides Immed).
3. A=0x7FFFFFFF, B=1, ADD -> ALU_out=0x80000000, Ovf=1. Then A=0x80000000, B=1, SUB -> 0x7FFFFFFF, Ovf=1. Then A=0x80000001, ROR -> 0xC0000000; SRA of 0x80000000 -> 0xC0000000.
4. A=7, B=6, MULU accepted at edge N -> Busy=1 for 32 cycles; In_valid with ADD during Busy is ignored; Out_valid at edge N+32 with ALU_out=42. A=0xFFFFFFFF, B=2 -> ALU_out=0xFFFFFFFE.
5. MULU A=3, B=4; Reset at edge N+10 -> Busy=0, In_ready=1, ALU_out=0, Zero=1; no Out_valid for 40 cycles. A subsequent ADD 2+3 yields 5 with latency 1.
6. Back-to-back: MULU completes, ADD accepted in the very next cycle -> two Out_valid pulses, one cycle apart, values 42 then 5. Unused code 1111 -> ALU_out=0, Zero=1.
